uart_cfg_decoder: RTL and testbench
===================================

# uart_cfg_decoder

Byte-stream command decoder for the configuration path. It consumes the byte/valid pulses produced by the UART receiver and assembles framed register-access commands. Each frame is checked for sync, command code, checksum and inter-byte timeout. Valid frames are issued as single-cycle write or read strobes toward the configuration register file.

## Interface

Parameters:
- DATA_BYTES, 4: payload bytes per write frame; o_Wr_Data width = 8*DATA_BYTES; legal range 1..8.
- TIMEOUT_CLKS, 100000: maximum clocks allowed between consecutive bytes of one frame; must be ≥ 2.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- i_Clock  input  1  sole clock; all logic on rising edge.
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_Rx_DV  input  1  one-cycle byte-valid pulse from the UART receiver.
- i_Rx_Byte  input  8  received byte, valid when i_Rx_DV=1.
- o_Wr_En  output  1  one-cycle write strobe.
- o_Rd_En  output  1  one-cycle read strobe.
- o_Addr  output  8  register address; holds between strobes.
- o_Wr_Data  output  8*DATA_BYTES  write data, big-endian (first payload byte = MSB); holds between write strobes.
- o_Frame_Err  output  1  one-cycle pulse on any frame error.
- o_Err_Count  output  8  saturating count of frame errors.
- o_Busy  output  1  high whenever the FSM is not in S_IDLE.

## Operation

- Frame format:
  - Write: SYNC, 0x01, ADDR, DATA_BYTES payload bytes, CSUM.
  - Read: SYNC, 0x02, ADDR, CSUM.
  - CSUM = XOR of CMD, ADDR and all payload bytes. SYNC is not included.
- FSM states:
  - S_IDLE: on i_Rx_DV with byte == SYNC_BYTE go to S_CMD. All other bytes are discarded silently (no error).
  - S_CMD: 0x01 or 0x02 → latch the command, go to S_ADDR. Any other value → error, go to S_IDLE.
  - S_ADDR: latch the address; go to S_DATA for a write, S_CSUM for a read.
  - S_DATA: shift each byte into the data shadow register. After DATA_BYTES bytes go to S_CSUM. A byte counter tracks the count.
  - S_CSUM: match → issue the strobe and go to S_IDLE. Mismatch → error, go to S_IDLE.
- A running XOR accumulator resets on SYNC and updates on every CMD/ADDR/DATA byte.
- o_Addr and o_Wr_Data update only when a valid strobe is issued; shadow registers hold the in-progress frame.
  - A read updates o_Addr only.
  - A failed frame never changes o_Addr or o_Wr_Data.
- Timeout:
  - The gap counter clears on every accepted byte and increments each cycle outside S_IDLE.
  - When it reaches TIMEOUT_CLKS-1 without a byte: error, go to S_IDLE.
  - It is inactive in S_IDLE.
- Error handling:
  - Each error pulses o_Frame_Err for one cycle and increments o_Err_Count.
  - o_Err_Count saturates at 255; it is never cleared except by reset.
- A SYNC_BYTE value received mid-frame is treated as ordinary data, not as a resync.

## Timing

- Reset (async assert, sync release):
  - All outputs 0.
  - FSM in S_IDLE; counters, accumulator and shadow registers 0.
- Latency: o_Wr_En, o_Rd_En or o_Frame_Err asserts in cycle N+1, where N is the cycle i_Rx_DV=1 carries the deciding byte. o_Addr and o_Wr_Data are valid in that same cycle N+1.
- Timeout error pulse: exactly TIMEOUT_CLKS cycles after the last accepted byte's i_Rx_DV cycle.
- o_Wr_En and o_Rd_En are never high together and never high for more than one cycle.
- i_Rx_DV is assumed to be at most one cycle per byte. Back-to-back i_Rx_DV in consecutive cycles must be accepted with no byte loss.
- Simultaneous events: if the timeout expiry coincides with i_Rx_DV, the byte wins; the counter clears and there is no error.
- o_Busy rises the cycle after SYNC is accepted and falls the cycle the strobe or error pulses.
- Reset asserted mid-frame aborts the frame: no strobe, no error count.

## Test plan

- Write frame: bytes A5 01 10 12 34 56 78 19 → one-cycle o_Wr_En, o_Addr=0x10, o_Wr_Data=0x12345678, no error.
- Read frame: bytes A5 02 20 22 → one-cycle o_Rd_En, o_Addr=0x20, o_Wr_Data unchanged, o_Wr_En stays 0.
- Errors:
  - Frame A5 01 10 12 34 56 78 18 (bad CSUM) → o_Frame_Err pulse, o_Err_Count=1, o_Addr/o_Wr_Data unchanged.
  - Frame A5 07 → error, count increments.
  - Leading bytes 00 FF before A5 → no error.
- Timeout, with TIMEOUT_CLKS=16:
  - Send A5 01, then idle → error exactly 16 cycles after the 01 pulse, o_Busy falls.
  - Repeat with the next byte arriving on cycle 16 → no error, frame continues.
- Saturation and reset: 300 bad frames → o_Err_Count=255. Assert i_Rst_n=0 mid-frame → all outputs 0 immediately. After release, a valid write frame completes normally.

Source files
------------

// File: rtl/uart_cfg_decoder.sv
// Assembles SYNC/CMD/ADDR/DATA/CSUM frames from UART bytes into register write/read strobes; decisions register one cycle after the deciding byte.
// No backpressure: every i_Rx_DV byte is consumed on arrival, and inter-byte gaps beyond TIMEOUT_CLKS abort the frame.
module uart_cfg_decoder #(
  parameter int          DATA_BYTES   = 4,
  parameter int          TIMEOUT_CLKS = 100000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                    i_Clock,
  input  logic                    i_Rst_n,
  input  logic                    i_Rx_DV,
  input  logic [7:0]              i_Rx_Byte,
  output logic                    o_Wr_En,
  output logic                    o_Rd_En,
  output logic [7:0]              o_Addr,
  output logic [8*DATA_BYTES-1:0] o_Wr_Data,
  output logic                    o_Frame_Err,
  output logic [7:0]              o_Err_Count,
  output logic                    o_Busy
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int GW = $clog2(TIMEOUT_CLKS) + 1;
  localparam int CW = 4;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CSUM
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gap_cnt;
  logic [CW-1:0]   byte_cnt;
  logic [7:0]      csum_acc;
  logic [7:0]      addr_sh;
  logic [DW-1:0]   data_sh;
  logic            cmd_wr;

  logic            timeout_hit;
  logic            cmd_ok;
  logic            csum_ok;
  logic            wr_fire;
  logic            rd_fire;
  logic            err_fire;

  assign cmd_ok  = (i_Rx_Byte == CMD_WR) || (i_Rx_Byte == CMD_RD);
  assign csum_ok = (i_Rx_Byte == csum_acc);
  // gap_cnt is about to reach TIMEOUT_CLKS-1; firing here lands the error pulse TIMEOUT_CLKS cycles after the last byte
  assign timeout_hit = !i_Rx_DV && (state != S_IDLE) && (gap_cnt == GW'(TIMEOUT_CLKS - 2));
  assign o_Busy = (state != S_IDLE);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (i_Rx_DV) begin
      case (state)
        S_IDLE: if (i_Rx_Byte == SYNC_BYTE) state_nxt = S_CMD;
        S_CMD:  state_nxt = cmd_ok ? S_ADDR : S_IDLE;
        S_ADDR: state_nxt = cmd_wr ? S_DATA : S_CSUM;
        S_DATA: if (byte_cnt == CW'(DATA_BYTES - 1)) state_nxt = S_CSUM;
        S_CSUM: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt = S_IDLE;
    end
  end

  always_comb begin
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    err_fire = timeout_hit;
    if (i_Rx_DV) begin
      case (state)
        S_CMD: if (!cmd_ok) err_fire = 1'b1;
        S_CSUM: begin
          if (csum_ok) begin
            wr_fire = cmd_wr;
            rd_fire = !cmd_wr;
          end else begin
            err_fire = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Wr_En     <= 1'b0;
      o_Rd_En     <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Err_Count <= 8'd0;
      o_Addr      <= 8'd0;
      o_Wr_Data   <= '0;
      gap_cnt     <= '0;
      byte_cnt    <= '0;
      csum_acc    <= 8'd0;
      addr_sh     <= 8'd0;
      data_sh     <= '0;
      cmd_wr      <= 1'b0;
    end else begin
      o_Wr_En     <= wr_fire;
      o_Rd_En     <= rd_fire;
      o_Frame_Err <= err_fire;
      if (err_fire && (o_Err_Count != 8'hFF)) o_Err_Count <= o_Err_Count + 8'd1;
      if (wr_fire) begin
        o_Addr    <= addr_sh;
        o_Wr_Data <= data_sh;
      end
      if (rd_fire) o_Addr <= addr_sh;

      if (i_Rx_DV || (state == S_IDLE)) gap_cnt <= '0;
      else                              gap_cnt <= gap_cnt + GW'(1);

      if (i_Rx_DV) begin
        case (state)
          S_IDLE: begin
            if (i_Rx_Byte == SYNC_BYTE) begin
              csum_acc <= 8'd0;
              byte_cnt <= '0;
            end
          end
          S_CMD: begin
            csum_acc <= csum_acc ^ i_Rx_Byte;
            cmd_wr   <= (i_Rx_Byte == CMD_WR);
          end
          S_ADDR: begin
            csum_acc <= csum_acc ^ i_Rx_Byte;
            addr_sh  <= i_Rx_Byte;
          end
          S_DATA: begin
            csum_acc <= csum_acc ^ i_Rx_Byte;
            data_sh  <= (data_sh << 8) | DW'(i_Rx_Byte);
            byte_cnt <= byte_cnt + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cfg_decoder.sv
// Directed bench for uart_cfg_decoder with DATA_BYTES=4, TIMEOUT_CLKS=16; inputs change and outputs are sampled 1ns after each rising edge.
module tb_uart_cfg_decoder;
  localparam int DATA_BYTES   = 4;
  localparam int TIMEOUT_CLKS = 16;

  logic        i_Clock   = 1'b0;
  logic        i_Rst_n   = 1'b0;
  logic        i_Rx_DV   = 1'b0;
  logic [7:0]  i_Rx_Byte = 8'h00;
  logic        o_Wr_En;
  logic        o_Rd_En;
  logic [7:0]  o_Addr;
  logic [31:0] o_Wr_Data;
  logic        o_Frame_Err;
  logic [7:0]  o_Err_Count;
  logic        o_Busy;

  int checks = 0;
  int errors = 0;
  logic seen_err;

  uart_cfg_decoder #(
    .DATA_BYTES  (DATA_BYTES),
    .TIMEOUT_CLKS(TIMEOUT_CLKS),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .i_Rx_DV    (i_Rx_DV),
    .i_Rx_Byte  (i_Rx_Byte),
    .o_Wr_En    (o_Wr_En),
    .o_Rd_En    (o_Rd_En),
    .o_Addr     (o_Addr),
    .o_Wr_Data  (o_Wr_Data),
    .o_Frame_Err(o_Frame_Err),
    .o_Err_Count(o_Err_Count),
    .o_Busy     (o_Busy)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte is presented for exactly one cycle; returns 1ns into the following cycle.
  task automatic send(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(posedge i_Clock);
    #1;
    i_Rx_DV   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #1;
    end
  endtask

  initial begin
    #2;
    check("rst_wr_en", o_Wr_En, 0);
    check("rst_rd_en", o_Rd_En, 0);
    check("rst_addr", o_Addr, 0);
    check("rst_data", o_Wr_Data, 0);
    check("rst_err", o_Frame_Err, 0);
    check("rst_cnt", o_Err_Count, 0);
    check("rst_busy", o_Busy, 0);
    idle(2);
    i_Rst_n = 1'b1;
    idle(2);

    // leading junk then a good write
    send(8'h00); send(8'hFF);
    check("junk_err", o_Frame_Err, 0);
    check("junk_busy", o_Busy, 0);
    send(8'hA5);
    check("sync_busy", o_Busy, 1);
    send(8'h01); send(8'h10); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    check("wr_pre_strobe", o_Wr_En, 0);
    send(8'h19);
    check("wr_en", o_Wr_En, 1);
    check("wr_rd_en", o_Rd_En, 0);
    check("wr_addr", o_Addr, 8'h10);
    check("wr_data", o_Wr_Data, 32'h12345678);
    check("wr_err", o_Frame_Err, 0);
    check("wr_busy", o_Busy, 0);
    idle(1);
    check("wr_en_1cyc", o_Wr_En, 0);

    // read
    send(8'hA5); send(8'h02); send(8'h20); send(8'h22);
    check("rd_en", o_Rd_En, 1);
    check("rd_wr_en", o_Wr_En, 0);
    check("rd_addr", o_Addr, 8'h20);
    check("rd_data_hold", o_Wr_Data, 32'h12345678);
    idle(1);
    check("rd_en_1cyc", o_Rd_En, 0);

    // bad checksum
    send(8'hA5); send(8'h01); send(8'h10); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h18);
    check("csum_err", o_Frame_Err, 1);
    check("csum_cnt", o_Err_Count, 1);
    check("csum_wr_en", o_Wr_En, 0);
    check("csum_addr", o_Addr, 8'h20);
    check("csum_data", o_Wr_Data, 32'h12345678);
    idle(1);
    check("csum_err_1cyc", o_Frame_Err, 0);

    // bad command
    send(8'hA5); send(8'h07);
    check("cmd_err", o_Frame_Err, 1);
    check("cmd_cnt", o_Err_Count, 2);
    check("cmd_busy", o_Busy, 0);

    // timeout: error lands 16 cycles after the 01 pulse
    idle(1);
    send(8'hA5); send(8'h01);
    seen_err = 1'b0;
    repeat (14) begin
      seen_err |= o_Frame_Err;
      idle(1);
    end
    seen_err |= o_Frame_Err;
    check("to_early", seen_err, 0);
    check("to_busy_hold", o_Busy, 1);
    idle(1);
    check("to_err", o_Frame_Err, 1);
    check("to_busy", o_Busy, 0);
    check("to_cnt", o_Err_Count, 3);

    // next byte on the last allowed cycle keeps the frame alive
    idle(1);
    send(8'hA5); send(8'h01);
    seen_err = 1'b0;
    repeat (14) begin
      seen_err |= o_Frame_Err;
      idle(1);
    end
    send(8'h33);
    seen_err |= o_Frame_Err;
    check("late_no_err", seen_err, 0);
    check("late_busy", o_Busy, 1);
    send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE); send(8'h02);
    check("late_wr_en", o_Wr_En, 1);
    check("late_addr", o_Addr, 8'h33);
    check("late_data", o_Wr_Data, 32'hCAFEBABE);
    check("late_cnt", o_Err_Count, 3);

    // SYNC value inside payload is plain data
    send(8'hA5); send(8'h01); send(8'h44); send(8'hA5); send(8'h00); send(8'h11); send(8'h22); send(8'hD3);
    check("midsync_wr_en", o_Wr_En, 1);
    check("midsync_addr", o_Addr, 8'h44);
    check("midsync_data", o_Wr_Data, 32'hA5001122);
    check("midsync_err", o_Frame_Err, 0);

    // saturation
    repeat (300) begin
      send(8'hA5); send(8'h07);
    end
    check("sat_cnt", o_Err_Count, 8'hFF);

    // reset mid-frame
    send(8'hA5); send(8'h01); send(8'h10);
    i_Rst_n = 1'b0;
    #1;
    check("arst_addr", o_Addr, 0);
    check("arst_data", o_Wr_Data, 0);
    check("arst_cnt", o_Err_Count, 0);
    check("arst_busy", o_Busy, 0);
    check("arst_wr_en", o_Wr_En, 0);
    idle(2);
    i_Rst_n = 1'b1;
    idle(1);
    send(8'hA5); send(8'h01); send(8'h10); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h19);
    check("post_rst_wr_en", o_Wr_En, 1);
    check("post_rst_addr", o_Addr, 8'h10);
    check("post_rst_data", o_Wr_Data, 32'h12345678);
    check("post_rst_cnt", o_Err_Count, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
